la_cmd_ctrl: RTL

UART command sequencer for the logic-analyzer capture engine in the LM32 system. It consumes bytes from the system UART and executes two commands: CMD_ARM (0x01) followed by four parameter bytes, and CMD_DISARM (0x02). It writes the select, trigger-mask, trigger-compare and pretrigger registers, then arms the capture engine. When the capture completes, it streams the whole sample memory back over UART TX.

---
 rtl/la_pkg.sv | 21 ++
 rtl/la_dump_seq.sv | 78 +++++++
 rtl/la_cmd_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared command codes and FSM state encoding for the logic-analyzer
// UART command sequencer.
package la_pkg;

    localparam logic [7:0] CMD_ARM    = 8'h01;
    localparam logic [7:0] CMD_DISARM = 8'h02;

    typedef enum logic [3:0] {
        IDLE,
        P_SEL,
        P_MASK,
        P_CMP,
        P_PRE,
        ARMED,
        D_ADR,
        D_DAT,
        D_TX,
        D_WAIT
    } la_state_t;

endpackage

// File: rtl/la_dump_seq.sv
// Sample-memory readback: walks 2**ADDR_W addresses from start_adr and
// hands each byte to the UART transmitter, honouring tx_busy.
module la_dump_seq
    import la_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_adr,
    input  logic              tx_busy,
    input  logic [7:0]        mem_dat,
    output logic              done,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic [ADDR_W-1:0] mem_adr,
    output logic              dumping
);

    la_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt;
    logic              abort_pend;
    logic              stop;

    // An abort seen mid-byte is remembered so the byte in flight still completes.
    assign stop = abort | abort_pend;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = D_ADR;
            D_ADR:   state_d = stop ? IDLE : D_DAT;
            D_DAT: begin
                if (stop)          state_d = IDLE;
                else if (!tx_busy) state_d = D_TX;
            end
            D_TX:    state_d = D_WAIT;
            D_WAIT:  if (!tx_busy) state_d = (stop || cnt == '1) ? IDLE : D_ADR;
            default: state_d = IDLE;
        endcase
    end

    assign done = (state_q != IDLE) && (state_d == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt        <= '0;
            abort_pend <= 1'b0;
            mem_adr    <= '0;
            tx_data    <= '0;
            tx_wr      <= 1'b0;
            dumping    <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_wr   <= 1'b0;
            if (state_q == IDLE && start) begin
                mem_adr    <= start_adr;
                cnt        <= '0;
                abort_pend <= 1'b0;
                dumping    <= 1'b1;
            end
            if (abort && state_q != IDLE) abort_pend <= 1'b1;
            if (state_q == D_DAT && state_d == D_TX) begin
                tx_data <= mem_dat;
                tx_wr   <= 1'b1;
            end
            if (state_q == D_WAIT && !tx_busy) begin
                mem_adr <= mem_adr + ADDR_W'(1);
                cnt     <= cnt + ADDR_W'(1);
            end
            if (done) dumping <= 1'b0;
        end
    end

endmodule

// File: rtl/la_cmd_ctrl.sv
// UART command parser for the capture engine: ARM with four parameter
// bytes, DISARM, and a sample-memory dump once capture completes.
module la_cmd_ctrl
    import la_pkg::*;
#(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned TIMEOUT = 50000000,
    parameter int unsigned TO_W    = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_avail,
    output logic              rx_ack,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic [7:0]        cfg_select,
    output logic [7:0]        cfg_mask,
    output logic [7:0]        cfg_cmp,
    output logic [7:0]        cfg_pretrig,
    output logic              armed,
    output logic              arm_start,
    input  logic              cap_done,
    input  logic [ADDR_W-1:0] cap_wptr,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [7:0]        mem_dat,
    output logic              dumping
);

    la_state_t       state_q, state_d;
    logic            ack_q;
    logic            take;
    logic [TO_W-1:0] to_cnt;
    logic            to_expired;
    logic            dump_start;
    logic            dump_abort;
    logic            dump_done;

    // The previous-cycle ack masks the next one so a held rx_avail is not consumed twice.
    assign rx_ack     = reset & rx_avail & ~ack_q;
    assign take       = rx_ack;
    assign to_expired = (to_cnt == TO_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        dump_start = 1'b0;
        dump_abort = 1'b0;
        case (state_q)
            IDLE:   if (take && rx_data == CMD_ARM) state_d = P_SEL;
            P_SEL:  if (take) state_d = P_MASK; else if (to_expired) state_d = IDLE;
            P_MASK: if (take) state_d = P_CMP;  else if (to_expired) state_d = IDLE;
            P_CMP:  if (take) state_d = P_PRE;  else if (to_expired) state_d = IDLE;
            P_PRE:  if (take) state_d = ARMED;  else if (to_expired) state_d = IDLE;
            ARMED: begin
                if (take && rx_data == CMD_DISARM) begin
                    state_d = IDLE;
                end else if (cap_done) begin
                    state_d    = D_ADR;
                    dump_start = 1'b1;
                end
            end
            // D_ADR here means the dump sequencer owns the transfer.
            D_ADR: begin
                dump_abort = take && (rx_data == CMD_DISARM);
                if (dump_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            to_cnt      <= '0;
            cfg_select  <= '0;
            cfg_mask    <= '0;
            cfg_cmp     <= '0;
            cfg_pretrig <= '0;
            armed       <= 1'b0;
            arm_start   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= rx_ack;
            arm_start <= 1'b0;
            if (take || !(state_q inside {P_SEL, P_MASK, P_CMP, P_PRE})) to_cnt <= '0;
            else if (!to_expired) to_cnt <= to_cnt + TO_W'(1);
            if (take) begin
                case (state_q)
                    P_SEL:  cfg_select <= rx_data;
                    P_MASK: cfg_mask   <= rx_data;
                    P_CMP:  cfg_cmp    <= rx_data;
                    P_PRE: begin
                        cfg_pretrig <= rx_data;
                        armed       <= 1'b1;
                        arm_start   <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state_q == ARMED && state_d != ARMED) armed <= 1'b0;
        end
    end

    la_dump_seq #(
        .ADDR_W(ADDR_W)
    ) u_dump (
        .clk      (clk),
        .reset    (reset),
        .start    (dump_start),
        .abort    (dump_abort),
        .start_adr(cap_wptr),
        .tx_busy  (tx_busy),
        .mem_dat  (mem_dat),
        .done     (dump_done),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .mem_adr  (mem_adr),
        .dumping  (dumping)
    );

endmodule
